// File: rtl/ttl_nand_share_ctrl.sv
// ttl_nand_share_ctrl: round-robin time-sharing of one external NAND gate among REQUESTERS clients
// Ports: Clk/Clear (sync active-high reset); Req per-client level request; A_2D packed operands;
// Gate_Y shared gate output; Gate_A registered gate inputs; Grant one-hot owner; Done one-cycle
// completion pulse; Result per-client captured Gate_Y; Busy high while settling.
module ttl_nand_share_ctrl #(
  parameter int REQUESTERS    = 4,
  parameter int WIDTH_IN      = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int DELAY_RISE    = 0,
  parameter int DELAY_FALL    = 0
) (
  input  logic                           Clk,
  input  logic                           Clear,
  input  logic [REQUESTERS-1:0]          Req,
  input  logic [REQUESTERS*WIDTH_IN-1:0] A_2D,
  input  logic                           Gate_Y,
  output logic [WIDTH_IN-1:0]            Gate_A,
  output logic [REQUESTERS-1:0]          Grant,
  output logic [REQUESTERS-1:0]          Done,
  output logic [REQUESTERS-1:0]          Result,
  output logic                           Busy
);
  localparam int IW = REQUESTERS > 1 ? $clog2(REQUESTERS) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic {S_IDLE, S_SETTLE} state_t;
  // Output delays only exist in the behavioural gate model; synthesized outputs are plain registers.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_neg_delay
  end
  state_t                r_state, w_next;
  logic [IW-1:0]         r_ptr, r_w, w_win;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH_IN-1:0]   r_gate_a;
  logic [REQUESTERS-1:0] r_grant, r_done, r_result, w_elig;
  logic                  r_busy, w_fire, w_finish;
  // A client finishing this cycle cannot re-win on its still-asserted Req.
  assign w_elig   = Req & ~r_done;
  assign w_fire   = r_state == S_IDLE && |w_elig;
  assign w_finish = r_state == S_SETTLE && r_cnt == '0;
  // Descending scan so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    w_win = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--)
      if (w_elig[(int'(r_ptr) + k) % REQUESTERS]) w_win = IW'((int'(r_ptr) + k) % REQUESTERS);
  end
  always_comb w_next = r_state == S_IDLE ? (w_fire ? S_SETTLE : S_IDLE) : (w_finish ? S_IDLE : S_SETTLE);
  always_ff @(posedge Clk)
    if (Clear) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_ptr    <= '0;
      r_w      <= '0;
      r_cnt    <= '0;
      r_gate_a <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= '0;
      if (w_fire) begin
        r_gate_a <= A_2D[w_win*WIDTH_IN +: WIDTH_IN];
        r_grant  <= REQUESTERS'(1) << w_win;
        r_w      <= w_win;
        r_busy   <= 1'b1;
        r_cnt    <= CW'(SETTLE_CYCLES - 1);
      end else if (r_state == S_SETTLE) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_result[r_w] <= Gate_Y;
          r_done        <= REQUESTERS'(1) << r_w;
          r_grant       <= '0;
          r_busy        <= 1'b0;
          r_ptr         <= r_w == IW'(REQUESTERS - 1) ? '0 : r_w + 1'b1;
        end
      end
    end
  end
  assign Gate_A = r_gate_a;
  assign Grant  = r_grant;
  assign Done   = r_done;
  assign Result = r_result;
  assign Busy   = r_busy;
endmodule

// File: tb/tb_ttl_nand_share_ctrl.sv
// tb_ttl_nand_share_ctrl: directed scoreboard bench for the shared-NAND round-robin controller
module tb_ttl_nand_share_ctrl;
  localparam int R = 4;
  localparam int W = 3;
  logic           Clk = 1'b0;
  logic           Clear = 1'b1;
  logic [R-1:0]   Req = '0;
  logic [R*W-1:0] A_2D = '0;
  logic           Gate_Y;
  logic [W-1:0]   Gate_A;
  logic [R-1:0]   Grant, Done, Result;
  logic           Busy;
  int             total = 0;
  int             bad = 0;
  int             q_cl[$];
  logic           q_res[$];
  logic [R-1:0]   model_res = '0;
  logic [W-1:0]   ops[R];
  ttl_nand_share_ctrl #(.REQUESTERS(R), .WIDTH_IN(W), .SETTLE_CYCLES(2), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk(Clk), .Clear(Clear), .Req(Req), .A_2D(A_2D), .Gate_Y(Gate_Y),
    .Gate_A(Gate_A), .Grant(Grant), .Done(Done), .Result(Result), .Busy(Busy)
  );
  assign Gate_Y = ~&Gate_A;
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int cl, input logic [W-1:0] v);
    ops[cl] = v;
    A_2D[cl*W +: W] = v;
  endtask
  task automatic granted(input string tag, input int cl);
    check({tag, "_grant"}, 32'(Grant), 32'(R'(1) << cl));
    check({tag, "_gate_a"}, 32'(Gate_A), 32'(ops[cl]));
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    q_cl.push_back(cl);
    q_res.push_back(~&ops[cl]);
  endtask
  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    int cl;
    logic r;
    do begin
      tick();
      n++;
    end while (Done == '0 && n < 10);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    if (q_cl.size() == 0) check({tag, "_sb_empty"}, 32'(Done), 32'd0);
    else begin
      cl = q_cl.pop_front();
      r = q_res.pop_front();
      model_res[cl] = r;
      check({tag, "_done"}, 32'(Done), 32'(R'(1) << cl));
      check({tag, "_result"}, 32'(Result), 32'(model_res));
      check({tag, "_busy_off"}, 32'(Busy), 32'd0);
      check({tag, "_grant_off"}, 32'(Grant), 32'd0);
    end
  endtask
  initial begin
    set_op(0, 3'b111); set_op(1, 3'b000); set_op(2, 3'b000); set_op(3, 3'b000);
    Req = 4'b1111;
    tick(); tick();
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_gate_a", 32'(Gate_A), 32'd0);
    Clear = 1'b0;
    tick();
    granted("first", 0);
    Req = '0;
    wait_done("first", 2);
    Req = 4'b0010; set_op(1, 3'b111);
    tick();
    granted("single_a", 1);
    Req = '0;
    wait_done("single_a", 2);
    tick();
    check("single_done_1cyc", 32'(Done), 32'd0);
    Req = 4'b0010; set_op(1, 3'b101);
    tick();
    granted("single_b", 1);
    Req = '0;
    wait_done("single_b", 2);
    Clear = 1'b1;
    model_res = '0;
    tick();
    Clear = 1'b0;
    set_op(0, 3'b110); set_op(1, 3'b111); set_op(2, 3'b011); set_op(3, 3'b000);
    Req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      granted($sformatf("rr%0d", i), i % R);
      wait_done($sformatf("rr%0d", i), 2);
    end
    Req = 4'b1010;
    tick();
    granted("wrap", 1);
    wait_done("wrap", 2);
    tick();
    granted("mask", 3);
    Req = '0;
    wait_done("mask", 2);
    set_op(0, 3'b111);
    Req = 4'b0001;
    tick();
    granted("capture", 0);
    A_2D[0 +: W] = 3'b000;
    Req = '0;
    tick();
    check("capture_hold_a", 32'(Gate_A), 32'b111);
    check("capture_hold_g", 32'(Grant), 32'b0001);
    wait_done("capture", 1);
    set_op(0, 3'b000);
    set_op(2, 3'b011);
    Req = 4'b0100;
    tick();
    check("abort_grant", 32'(Grant), 32'b0100);
    Req = '0;
    Clear = 1'b1;
    model_res = '0;
    tick();
    Clear = 1'b0;
    check("abort_grant_off", 32'(Grant), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), 32'(Done), 32'd0);
    end
    Req = 4'b0100;
    tick();
    granted("after_abort", 2);
    Req = '0;
    wait_done("after_abort", 2);
    check("sb_drained", 32'(q_cl.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ttl_nand_share_ctrl.md
Name: ttl_nand_share_ctrl

Overview:
Round-robin controller that time-shares one external NAND gate block among REQUESTERS clients. It latches the winning client's operand onto the shared gate inputs and waits SETTLE_CYCLES for the gate output to settle. It then captures the gate output into that client's result bit and pulses that client's Done. It sits between several logic-model consumers and a single gate model instance (BLOCKS=1, WIDTH_IN=WIDTH_IN).

Parameters:
REQUESTERS, 4, number of clients (>=2)
WIDTH_IN, 3, operand width per client = shared gate input width
SETTLE_CYCLES, 2, cycles Gate_A is held before Gate_Y is sampled (>=1)
DELAY_RISE, 0, rise delay applied to all outputs
DELAY_FALL, 0, fall delay applied to all outputs

Ports:
Clk  input  1  clock, rising edge
Clear  input  1  synchronous active-high reset
Req  input  REQUESTERS  per-client request, level
A_2D  input  REQUESTERS*WIDTH_IN  packed operands, client i at bits [i*WIDTH_IN +: WIDTH_IN]
Gate_Y  input  1  output of shared NAND gate
Gate_A  output  WIDTH_IN  inputs to shared NAND gate, registered
Grant  output  REQUESTERS  one-hot, client currently owning the gate
Done  output  REQUESTERS  one-hot, one-cycle completion pulse
Result  output  REQUESTERS  per-client last captured Gate_Y, registered
Busy  output  1  high while in SETTLE

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Clear). All state changes on the rising Clk edge.
- Reset (Clear=1 at edge):
  - state=IDLE, pointer=0, Gate_A=0, Grant=0, Done=0, Result=0, Busy=0.
  - Clear overrides all other inputs.
- States: IDLE, SETTLE.
- IDLE:
  - Eligible set = Req with bit i masked when Done[i]=1 in the current cycle. This prevents a client re-winning on a stale Req.
  - If the eligible set is nonzero, the winner w is the first set bit searching pointer, pointer+1, ..., wrapping modulo REQUESTERS.
  - At the edge: Gate_A<=A_2D slice w, Grant<=onehot(w), Busy<=1, count<=SETTLE_CYCLES-1, state<=SETTLE.
  - If no client is eligible, remain in IDLE.
  - Done is cleared at every edge that does not complete an operation.
- SETTLE:
  - Gate_A and Grant are held constant. Changes on A_2D or Req are ignored; the operand was captured at grant.
  - If count!=0: count<=count-1.
  - If count==0: Result[w]<=Gate_Y, Done<=onehot(w), Grant<=0, Busy<=0, pointer<=(w+1) mod REQUESTERS, state<=IDLE.
  - Other Result bits are unchanged.
  - Gate_A keeps its last value in IDLE.
- Timing, with the grant taken at edge k:
  - Grant/Gate_A valid from k to k+SETTLE_CYCLES.
  - Gate_Y is sampled at edge k+SETTLE_CYCLES.
  - Done is high for exactly the one cycle after k+SETTLE_CYCLES.
  - The next grant can occur at edge k+SETTLE_CYCLES+1.
  - Sustained throughput is one operation per SETTLE_CYCLES+1 cycles.
- A client dropping Req during SETTLE does not abort: the operation completes and Done/Result still update.
- A client holding Req continuously is re-served only after every other requesting client has been served (fairness). Its own Req is ignored in its Done cycle.
- Clear mid-SETTLE abandons the operation: no Done, no Result update, pointer=0.
- The gate is combinational and external; the controller never drives Gate_A for more than one client at a time.
- Outputs pass through #(DELAY_RISE, DELAY_FALL); the bench uses 0/0.

Test Plan:
1. Reset: hold Clear 2 cycles with Req=4'b1111 -> Grant=0, Done=0, Result=0, Busy=0, Gate_A=0; the first grant after release goes to client 0.
2. Single op, SETTLE_CYCLES=2: Req=4'b0010, A slice1=3'b111 at edge k:
   - Grant=4'b0010 and Gate_A=3'b111 after k.
   - Done=4'b0010 for one cycle after k+2; Result[1]=0.
   - Repeat with 3'b101 -> Result[1]=1.
3. Contention: Req=4'b1111 held, distinct operands -> grant order 0,1,2,3,0; Done pulses spaced 3 cycles apart; each Result bit equals the NAND of its operand.
4. Pointer wrap and masking:
   - After client 3 completes, Req=4'b1010 -> client 1 wins.
   - Client 1 holds Req with Req[3]=1 -> client 3 wins next, not client 1.
5. Operand capture: change A slice0 from 3'b111 to 3'b000 one cycle after grant -> Gate_A stays 3'b111 and Result[0]=0. Drop Req[0] mid-SETTLE -> Done[0] still pulses.
6. Clear mid-SETTLE: assert Clear at edge k+1 of an op for client 2 -> no Done[2], Result[2] unchanged (0), Grant=0; the next request from client 2 is granted normally.
